rs: RTL and testbench

RS -- requirements
Module: rs

---
 rtl/rs.sv | 241 ++++++++++++++++++++++++
 tb/tb_rs.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rs.sv
// rtl/rs.sv - 16-entry dual-dispatch, dual-issue reservation station
module rs (
   input  logic        clock,
   input  logic        reset,
   input  logic        ex_alu_full,
   input  logic        ex_mulq_full,
   input  logic        ex_ld_full,
   input  logic        ex_sv_full,
   input  logic [5:0]  ex_cm_cdbAIdx,
   input  logic [5:0]  ex_cm_cdbBIdx,
   input  logic        ex_cm_cdbA_en,
   input  logic        ex_cm_cdbB_en,
   input  logic [5:0]  fl_TA,
   input  logic [5:0]  fl_TB,
   input  logic [31:0] id_IRA,
   input  logic [31:0] id_IRB,
   input  logic        id_IRA_valid,
   input  logic        id_IRB_valid,
   input  logic [4:0]  id_alu_funcA,
   input  logic [4:0]  id_alu_funcB,
   input  logic [1:0]  id_op1A_select,
   input  logic [1:0]  id_op1B_select,
   input  logic [1:0]  id_op2A_select,
   input  logic [1:0]  id_op2B_select,
   input  logic [6:0]  mt_T1A,
   input  logic [6:0]  mt_T1B,
   input  logic [6:0]  mt_T2A,
   input  logic [6:0]  mt_T2B,
   input  logic [4:0]  mt_archIdxA,
   input  logic [4:0]  mt_archIdxB,
   input  logic [4:0]  rob_idxA,
   input  logic [4:0]  rob_idxB,
   input  logic        rob_instA_en,
   input  logic        rob_instB_en,
   output logic [3:0]  initFreeA,
   output logic        rs_busy_out,
   output logic        rs_almostFull_out,
   output logic [2:0]  rs_issueA_out,
   output logic [2:0]  rs_issueB_out,
   output logic        rs_issueArdy_out,
   output logic        rs_issueBrdy_out,
   output logic [31:0] rs_IRA_out,
   output logic [31:0] rs_IRB_out,
   output logic [5:0]  rs_T1A_out,
   output logic [5:0]  rs_T1B_out,
   output logic [5:0]  rs_T2A_out,
   output logic [5:0]  rs_T2B_out,
   output logic [5:0]  rs_TA_out,
   output logic [5:0]  rs_TB_out,
   output logic [4:0]  rs_alu_funcA_out,
   output logic [4:0]  rs_alu_funcB_out,
   output logic [1:0]  rs_op1A_select_out,
   output logic [1:0]  rs_op1B_select_out,
   output logic [1:0]  rs_op2A_select_out,
   output logic [1:0]  rs_op2B_select_out,
   output logic [4:0]  rs_rob_idxA_out,
   output logic [4:0]  rs_rob_idxB_out
);

   localparam int N = 16;
   localparam logic [2:0] CLS_ALU = 3'd1;
   localparam logic [2:0] CLS_MUL = 3'd2;
   localparam logic [2:0] CLS_LD  = 3'd3;
   localparam logic [2:0] CLS_ST  = 3'd4;

   logic        busy_q [N];
   logic [31:0] ir_q   [N];
   logic [4:0]  func_q [N];
   logic [1:0]  op1_q  [N];
   logic [1:0]  op2_q  [N];
   logic [6:0]  t1_q   [N];
   logic [6:0]  t2_q   [N];
   logic [5:0]  ta_q   [N];
   logic [4:0]  rob_q  [N];
   logic [2:0]  cls_q  [N];

   logic        free_a_ok, free_b_ok;
   logic [3:0]  free_a_idx, free_b_idx;
   logic [4:0]  free_cnt;
   logic        dis_a, dis_b;
   logic [3:0]  dis_b_idx;
   logic [2:0]  cls_a, cls_b;
   logic        rdy_a1, rdy_a2, rdy_b1, rdy_b2;
   logic [N-1:0] hit1, hit2, elig;
   logic        iss_a_ok, iss_b_ok;
   logic [3:0]  iss_a_idx, iss_b_idx;

   // architectural destination is not needed by the station
   logic unused_arch;
   assign unused_arch = ^{mt_archIdxA, mt_archIdxB};

   function automatic logic [2:0] classify(input logic [31:0] ir, input logic [4:0] func);
      if (ir[31:26] == 6'h29)      return CLS_LD;
      else if (ir[31:26] == 6'h2D) return CLS_ST;
      else if (func == 5'd11)      return CLS_MUL;
      else                         return CLS_ALU;
   endfunction

   function automatic logic cdb_hit(input logic [5:0] tag, input logic en_a, input logic [5:0] idx_a,
                                    input logic en_b, input logic [5:0] idx_b);
      return (en_a && tag == idx_a) || (en_b && tag == idx_b);
   endfunction

   // free-entry search, occupancy count and dispatch slot selection
   always_comb begin
      free_a_ok  = 1'b0;
      free_a_idx = 4'd0;
      free_b_ok  = 1'b0;
      free_b_idx = 4'd0;
      free_cnt   = 5'd0;
      for (int i = N - 1; i >= 0; i--) begin
         if (!busy_q[i]) begin
            free_a_ok  = 1'b1;
            free_a_idx = 4'(i);
            free_cnt   = free_cnt + 5'd1;
         end
      end
      for (int i = N - 1; i >= 0; i--) begin
         if (!busy_q[i] && 4'(i) != free_a_idx) begin
            free_b_ok  = 1'b1;
            free_b_idx = 4'(i);
         end
      end
      dis_a     = rob_instA_en && id_IRA_valid && free_a_ok;
      dis_b     = rob_instB_en && id_IRB_valid && (dis_a ? free_b_ok : free_a_ok);
      dis_b_idx = dis_a ? free_b_idx : free_a_idx;
      cls_a     = classify(id_IRA, id_alu_funcA);
      cls_b     = classify(id_IRB, id_alu_funcB);
      rdy_a1    = mt_T1A[6] || cdb_hit(mt_T1A[5:0], ex_cm_cdbA_en, ex_cm_cdbAIdx, ex_cm_cdbB_en, ex_cm_cdbBIdx);
      rdy_a2    = mt_T2A[6] || cdb_hit(mt_T2A[5:0], ex_cm_cdbA_en, ex_cm_cdbAIdx, ex_cm_cdbB_en, ex_cm_cdbBIdx);
      rdy_b1    = mt_T1B[6] || cdb_hit(mt_T1B[5:0], ex_cm_cdbA_en, ex_cm_cdbAIdx, ex_cm_cdbB_en, ex_cm_cdbBIdx);
      rdy_b2    = mt_T2B[6] || cdb_hit(mt_T2B[5:0], ex_cm_cdbA_en, ex_cm_cdbAIdx, ex_cm_cdbB_en, ex_cm_cdbBIdx);
   end

   // wakeup matches, eligibility and the two lowest-index issue picks
   always_comb begin
      hit1      = '0;
      hit2      = '0;
      elig      = '0;
      iss_a_ok  = 1'b0;
      iss_a_idx = 4'd0;
      iss_b_ok  = 1'b0;
      iss_b_idx = 4'd0;
      for (int i = 0; i < N; i++) begin
         hit1[i] = cdb_hit(t1_q[i][5:0], ex_cm_cdbA_en, ex_cm_cdbAIdx, ex_cm_cdbB_en, ex_cm_cdbBIdx);
         hit2[i] = cdb_hit(t2_q[i][5:0], ex_cm_cdbA_en, ex_cm_cdbAIdx, ex_cm_cdbB_en, ex_cm_cdbBIdx);
         elig[i] = busy_q[i] && t1_q[i][6] && t2_q[i][6] &&
                   !((cls_q[i] == CLS_ALU && ex_alu_full) || (cls_q[i] == CLS_MUL && ex_mulq_full) ||
                     (cls_q[i] == CLS_LD && ex_ld_full)   || (cls_q[i] == CLS_ST && ex_sv_full));
      end
      for (int i = N - 1; i >= 0; i--) begin
         if (elig[i]) begin
            iss_a_ok  = 1'b1;
            iss_a_idx = 4'(i);
         end
      end
      for (int i = N - 1; i >= 0; i--) begin
         if (elig[i] && 4'(i) != iss_a_idx) begin
            iss_b_ok  = 1'b1;
            iss_b_idx = 4'(i);
         end
      end
   end

   // occupancy flags and issue-port fields, zeroed when a port is idle
   always_comb begin
      initFreeA          = free_a_idx;
      rs_busy_out        = (free_cnt == 5'd0);
      rs_almostFull_out  = (free_cnt == 5'd1);
      rs_issueArdy_out   = iss_a_ok;
      rs_issueBrdy_out   = iss_b_ok;
      rs_issueA_out      = iss_a_ok ? cls_q[iss_a_idx]  : 3'd0;
      rs_issueB_out      = iss_b_ok ? cls_q[iss_b_idx]  : 3'd0;
      rs_IRA_out         = iss_a_ok ? ir_q[iss_a_idx]   : 32'd0;
      rs_IRB_out         = iss_b_ok ? ir_q[iss_b_idx]   : 32'd0;
      rs_T1A_out         = iss_a_ok ? t1_q[iss_a_idx][5:0] : 6'd0;
      rs_T1B_out         = iss_b_ok ? t1_q[iss_b_idx][5:0] : 6'd0;
      rs_T2A_out         = iss_a_ok ? t2_q[iss_a_idx][5:0] : 6'd0;
      rs_T2B_out         = iss_b_ok ? t2_q[iss_b_idx][5:0] : 6'd0;
      rs_TA_out          = iss_a_ok ? ta_q[iss_a_idx]   : 6'd0;
      rs_TB_out          = iss_b_ok ? ta_q[iss_b_idx]   : 6'd0;
      rs_alu_funcA_out   = iss_a_ok ? func_q[iss_a_idx] : 5'd0;
      rs_alu_funcB_out   = iss_b_ok ? func_q[iss_b_idx] : 5'd0;
      rs_op1A_select_out = iss_a_ok ? op1_q[iss_a_idx]  : 2'd0;
      rs_op1B_select_out = iss_b_ok ? op1_q[iss_b_idx]  : 2'd0;
      rs_op2A_select_out = iss_a_ok ? op2_q[iss_a_idx]  : 2'd0;
      rs_op2B_select_out = iss_b_ok ? op2_q[iss_b_idx]  : 2'd0;
      rs_rob_idxA_out    = iss_a_ok ? rob_q[iss_a_idx]  : 5'd0;
      rs_rob_idxB_out    = iss_b_ok ? rob_q[iss_b_idx]  : 5'd0;
   end

   // entry storage: reset clear, CDB wakeup, issue free, dispatch write
   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < N; i++) begin
            busy_q[i] <= 1'b0;
            ir_q[i]   <= 32'd0;
            func_q[i] <= 5'd0;
            op1_q[i]  <= 2'd0;
            op2_q[i]  <= 2'd0;
            t1_q[i]   <= 7'd0;
            t2_q[i]   <= 7'd0;
            ta_q[i]   <= 6'd0;
            rob_q[i]  <= 5'd0;
            cls_q[i]  <= 3'd0;
         end
      end else begin
         for (int i = 0; i < N; i++) begin
            if (busy_q[i] && hit1[i]) t1_q[i][6] <= 1'b1;
            if (busy_q[i] && hit2[i]) t2_q[i][6] <= 1'b1;
            if ((iss_a_ok && iss_a_idx == 4'(i)) || (iss_b_ok && iss_b_idx == 4'(i)))
               busy_q[i] <= 1'b0;
            if (dis_a && free_a_idx == 4'(i)) begin
               busy_q[i] <= 1'b1;
               ir_q[i]   <= id_IRA;
               func_q[i] <= id_alu_funcA;
               op1_q[i]  <= id_op1A_select;
               op2_q[i]  <= id_op2A_select;
               t1_q[i]   <= {rdy_a1, mt_T1A[5:0]};
               t2_q[i]   <= {rdy_a2, mt_T2A[5:0]};
               ta_q[i]   <= fl_TA;
               rob_q[i]  <= rob_idxA;
               cls_q[i]  <= cls_a;
            end
            if (dis_b && dis_b_idx == 4'(i)) begin
               busy_q[i] <= 1'b1;
               ir_q[i]   <= id_IRB;
               func_q[i] <= id_alu_funcB;
               op1_q[i]  <= id_op1B_select;
               op2_q[i]  <= id_op2B_select;
               t1_q[i]   <= {rdy_b1, mt_T1B[5:0]};
               t2_q[i]   <= {rdy_b2, mt_T2B[5:0]};
               ta_q[i]   <= fl_TB;
               rob_q[i]  <= rob_idxB;
               cls_q[i]  <= cls_b;
            end
         end
      end
   end

endmodule

// File: tb/tb_rs.sv
// tb/tb_rs.sv - directed self-checking bench for rs
module tb_rs;

   logic        clock = 1'b0;
   logic        reset;
   logic        ex_alu_full, ex_mulq_full, ex_ld_full, ex_sv_full;
   logic [5:0]  ex_cm_cdbAIdx, ex_cm_cdbBIdx;
   logic        ex_cm_cdbA_en, ex_cm_cdbB_en;
   logic [5:0]  fl_TA, fl_TB;
   logic [31:0] id_IRA, id_IRB;
   logic        id_IRA_valid, id_IRB_valid;
   logic [4:0]  id_alu_funcA, id_alu_funcB;
   logic [1:0]  id_op1A_select, id_op1B_select, id_op2A_select, id_op2B_select;
   logic [6:0]  mt_T1A, mt_T1B, mt_T2A, mt_T2B;
   logic [4:0]  mt_archIdxA, mt_archIdxB;
   logic [4:0]  rob_idxA, rob_idxB;
   logic        rob_instA_en, rob_instB_en;
   logic [3:0]  initFreeA;
   logic        rs_busy_out, rs_almostFull_out;
   logic [2:0]  rs_issueA_out, rs_issueB_out;
   logic        rs_issueArdy_out, rs_issueBrdy_out;
   logic [31:0] rs_IRA_out, rs_IRB_out;
   logic [5:0]  rs_T1A_out, rs_T1B_out, rs_T2A_out, rs_T2B_out, rs_TA_out, rs_TB_out;
   logic [4:0]  rs_alu_funcA_out, rs_alu_funcB_out;
   logic [1:0]  rs_op1A_select_out, rs_op1B_select_out, rs_op2A_select_out, rs_op2B_select_out;
   logic [4:0]  rs_rob_idxA_out, rs_rob_idxB_out;

   int total = 0;
   int bad   = 0;

   rs dut (
      .clock(clock), .reset(reset),
      .ex_alu_full(ex_alu_full), .ex_mulq_full(ex_mulq_full),
      .ex_ld_full(ex_ld_full), .ex_sv_full(ex_sv_full),
      .ex_cm_cdbAIdx(ex_cm_cdbAIdx), .ex_cm_cdbBIdx(ex_cm_cdbBIdx),
      .ex_cm_cdbA_en(ex_cm_cdbA_en), .ex_cm_cdbB_en(ex_cm_cdbB_en),
      .fl_TA(fl_TA), .fl_TB(fl_TB),
      .id_IRA(id_IRA), .id_IRB(id_IRB),
      .id_IRA_valid(id_IRA_valid), .id_IRB_valid(id_IRB_valid),
      .id_alu_funcA(id_alu_funcA), .id_alu_funcB(id_alu_funcB),
      .id_op1A_select(id_op1A_select), .id_op1B_select(id_op1B_select),
      .id_op2A_select(id_op2A_select), .id_op2B_select(id_op2B_select),
      .mt_T1A(mt_T1A), .mt_T1B(mt_T1B), .mt_T2A(mt_T2A), .mt_T2B(mt_T2B),
      .mt_archIdxA(mt_archIdxA), .mt_archIdxB(mt_archIdxB),
      .rob_idxA(rob_idxA), .rob_idxB(rob_idxB),
      .rob_instA_en(rob_instA_en), .rob_instB_en(rob_instB_en),
      .initFreeA(initFreeA),
      .rs_busy_out(rs_busy_out), .rs_almostFull_out(rs_almostFull_out),
      .rs_issueA_out(rs_issueA_out), .rs_issueB_out(rs_issueB_out),
      .rs_issueArdy_out(rs_issueArdy_out), .rs_issueBrdy_out(rs_issueBrdy_out),
      .rs_IRA_out(rs_IRA_out), .rs_IRB_out(rs_IRB_out),
      .rs_T1A_out(rs_T1A_out), .rs_T1B_out(rs_T1B_out),
      .rs_T2A_out(rs_T2A_out), .rs_T2B_out(rs_T2B_out),
      .rs_TA_out(rs_TA_out), .rs_TB_out(rs_TB_out),
      .rs_alu_funcA_out(rs_alu_funcA_out), .rs_alu_funcB_out(rs_alu_funcB_out),
      .rs_op1A_select_out(rs_op1A_select_out), .rs_op1B_select_out(rs_op1B_select_out),
      .rs_op2A_select_out(rs_op2A_select_out), .rs_op2B_select_out(rs_op2B_select_out),
      .rs_rob_idxA_out(rs_rob_idxA_out), .rs_rob_idxB_out(rs_rob_idxB_out)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic idle();
      ex_alu_full = 0; ex_mulq_full = 0; ex_ld_full = 0; ex_sv_full = 0;
      ex_cm_cdbAIdx = 0; ex_cm_cdbBIdx = 0; ex_cm_cdbA_en = 0; ex_cm_cdbB_en = 0;
      fl_TA = 0; fl_TB = 0; id_IRA = 0; id_IRB = 0; id_IRA_valid = 0; id_IRB_valid = 0;
      id_alu_funcA = 0; id_alu_funcB = 0;
      id_op1A_select = 0; id_op1B_select = 0; id_op2A_select = 0; id_op2B_select = 0;
      mt_T1A = 0; mt_T1B = 0; mt_T2A = 0; mt_T2B = 0; mt_archIdxA = 0; mt_archIdxB = 0;
      rob_idxA = 0; rob_idxB = 0; rob_instA_en = 0; rob_instB_en = 0;
   endtask

   task automatic set_a(input logic [31:0] ir, input logic [4:0] func, input logic [6:0] t1,
                        input logic [6:0] t2, input logic [5:0] ta, input logic [4:0] rob);
      id_IRA = ir; id_alu_funcA = func; mt_T1A = t1; mt_T2A = t2; fl_TA = ta; rob_idxA = rob;
      id_IRA_valid = 1; rob_instA_en = 1;
   endtask

   task automatic set_b(input logic [31:0] ir, input logic [4:0] func, input logic [6:0] t1,
                        input logic [6:0] t2, input logic [5:0] ta, input logic [4:0] rob);
      id_IRB = ir; id_alu_funcB = func; mt_T1B = t1; mt_T2B = t2; fl_TB = ta; rob_idxB = rob;
      id_IRB_valid = 1; rob_instB_en = 1;
   endtask

   initial begin
      idle();
      reset = 1;
      step(); step();
      reset = 0;
      chk("rst_initfree", 32'(initFreeA), 0);
      chk("rst_busy", 32'(rs_busy_out), 0);
      chk("rst_afull", 32'(rs_almostFull_out), 0);
      chk("rst_rdyA", 32'(rs_issueArdy_out), 0);
      chk("rst_clsA", 32'(rs_issueA_out), 0);
      chk("rst_irA", rs_IRA_out, 0);

      // ready ALU dispatch issues next cycle
      set_a(32'h0000_1234, 5'd3, 7'h41, 7'h42, 6'd10, 5'd3);
      id_op1A_select = 2'd2; id_op2A_select = 2'd1;
      step(); idle();
      chk("d1_rdyA", 32'(rs_issueArdy_out), 1);
      chk("d1_clsA", 32'(rs_issueA_out), 1);
      chk("d1_TA", 32'(rs_TA_out), 10);
      chk("d1_rob", 32'(rs_rob_idxA_out), 3);
      chk("d1_T1", 32'(rs_T1A_out), 1);
      chk("d1_T2", 32'(rs_T2A_out), 2);
      chk("d1_ir", rs_IRA_out, 32'h0000_1234);
      chk("d1_func", 32'(rs_alu_funcA_out), 3);
      chk("d1_op1", 32'(rs_op1A_select_out), 2);
      chk("d1_op2", 32'(rs_op2A_select_out), 1);
      chk("d1_rdyB", 32'(rs_issueBrdy_out), 0);
      chk("d1_initfree", 32'(initFreeA), 1);
      step();
      chk("d1_freed_rdy", 32'(rs_issueArdy_out), 0);
      chk("d1_freed_init", 32'(initFreeA), 0);
      chk("d1_idle_TA", 32'(rs_TA_out), 0);

      // not-ready source woken by CDB A
      set_a(32'h0, 5'd0, 7'd15, 7'h40, 6'd11, 5'd4);
      step(); idle();
      chk("w_wait_rdy", 32'(rs_issueArdy_out), 0);
      ex_cm_cdbAIdx = 6'd15; ex_cm_cdbA_en = 1;
      step(); idle();
      chk("w_rdy", 32'(rs_issueArdy_out), 1);
      chk("w_T1", 32'(rs_T1A_out), 15);
      step();

      // CDB B bypass on the dispatch edge
      set_a(32'h0, 5'd0, 7'd30, 7'h40, 6'd12, 5'd5);
      ex_cm_cdbBIdx = 6'd30; ex_cm_cdbB_en = 1;
      step(); idle();
      chk("byp_rdy", 32'(rs_issueArdy_out), 1);
      chk("byp_T1", 32'(rs_T1A_out), 30);
      step();

      // dual dispatch, dual issue in index order; slot B is a load
      set_a(32'h0, 5'd0, 7'h41, 7'h42, 6'd5, 5'd7);
      set_b(32'hA400_0000, 5'd0, 7'h43, 7'h44, 6'd6, 5'd8);
      step(); idle();
      chk("dual_rdyA", 32'(rs_issueArdy_out), 1);
      chk("dual_TA", 32'(rs_TA_out), 5);
      chk("dual_robA", 32'(rs_rob_idxA_out), 7);
      chk("dual_clsA", 32'(rs_issueA_out), 1);
      chk("dual_rdyB", 32'(rs_issueBrdy_out), 1);
      chk("dual_TB", 32'(rs_TB_out), 6);
      chk("dual_robB", 32'(rs_rob_idxB_out), 8);
      chk("dual_clsB", 32'(rs_issueB_out), 3);
      chk("dual_initfree", 32'(initFreeA), 2);
      step();

      // multiplier held back by mulq full
      set_a(32'h0, 5'd11, 7'h41, 7'h42, 6'd20, 5'd9);
      ex_mulq_full = 1;
      step(); idle();
      ex_mulq_full = 1;
      #1;
      chk("mul_hold", 32'(rs_issueArdy_out), 0);
      ex_mulq_full = 0;
      #1;
      chk("mul_rdy", 32'(rs_issueArdy_out), 1);
      chk("mul_cls", 32'(rs_issueA_out), 2);
      step();

      // store held back by sv full
      set_a(32'hB400_0000, 5'd0, 7'h41, 7'h42, 6'd21, 5'd10);
      ex_sv_full = 1;
      step();
      rob_instA_en = 0; id_IRA_valid = 0;
      #1;
      chk("st_hold", 32'(rs_issueArdy_out), 0);
      ex_sv_full = 0;
      #1;
      chk("st_cls", 32'(rs_issueA_out), 4);
      step(); idle();

      // fill to almost full, then full, then drop
      for (int i = 0; i < 15; i++) begin
         set_a(32'h0, 5'd0, 7'd20, 7'd21, 6'(i), 5'(i));
         step();
      end
      idle();
      chk("fill_afull", 32'(rs_almostFull_out), 1);
      chk("fill_busy", 32'(rs_busy_out), 0);
      chk("fill_init", 32'(initFreeA), 15);
      set_a(32'h0, 5'd0, 7'd20, 7'd21, 6'd15, 5'd15);
      step(); idle();
      chk("full_busy", 32'(rs_busy_out), 1);
      chk("full_afull", 32'(rs_almostFull_out), 0);
      chk("full_init", 32'(initFreeA), 0);
      set_a(32'h0, 5'd0, 7'h41, 7'h42, 6'd33, 5'd1);
      step(); idle();
      chk("drop_rdy", 32'(rs_issueArdy_out), 0);
      chk("drop_busy", 32'(rs_busy_out), 1);
      ex_cm_cdbAIdx = 6'd20; ex_cm_cdbA_en = 1;
      ex_cm_cdbBIdx = 6'd21; ex_cm_cdbB_en = 1;
      step(); idle();
      chk("wake_TA", 32'(rs_TA_out), 0);
      chk("wake_TB", 32'(rs_TB_out), 1);
      chk("wake_rdyB", 32'(rs_issueBrdy_out), 1);

      // reset with busy entries, overriding a simultaneous dispatch
      reset = 1;
      step();
      reset = 0;
      for (int i = 0; i < 5; i++) begin
         set_a(32'h0, 5'd0, 7'd40, 7'h41, 6'(i), 5'(i));
         step();
      end
      idle();
      chk("r5_init", 32'(initFreeA), 5);
      reset = 1;
      set_a(32'h0, 5'd0, 7'h41, 7'h42, 6'd9, 5'd9);
      ex_cm_cdbAIdx = 6'd40; ex_cm_cdbA_en = 1;
      step(); idle();
      reset = 0;
      chk("r5_init0", 32'(initFreeA), 0);
      chk("r5_busy", 32'(rs_busy_out), 0);
      chk("r5_afull", 32'(rs_almostFull_out), 0);
      chk("r5_rdyA", 32'(rs_issueArdy_out), 0);
      chk("r5_rdyB", 32'(rs_issueBrdy_out), 0);
      chk("r5_TA", 32'(rs_TA_out), 0);
      step();
      chk("r5_after_rdy", 32'(rs_issueArdy_out), 0);
      chk("r5_after_init", 32'(initFreeA), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
